// File: rtl/nx_fifo_wm.sv
// nx_fifo_wm: single-clock first-word-fall-through FIFO with registered
// occupancy counts, watermark flags, a high-water mark and error reporting.
// Depth may be any value from 2 to 1024; the pointers wrap explicitly at
// DEPTH-1, so depths that are not powers of two never alias.
module nx_fifo_wm #(
    parameter int DEPTH      = 4,
    parameter int WIDTH      = 96,
    parameter int AFULL_TH   = DEPTH - 1,
    parameter int AEMPTY_TH  = 1,
    parameter bit DATA_RESET = 1'b1,
    localparam int CW        = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             wen,
    input  logic [WIDTH-1:0] wdata,
    input  logic             ren,
    output logic [WIDTH-1:0] rdata,
    output logic             empty,
    output logic             full,
    output logic             almost_empty,
    output logic             almost_full,
    output logic [CW-1:0]    used_slots,
    output logic [CW-1:0]    free_slots,
    output logic [CW-1:0]    high_water,
    output logic             underflow,
    output logic             overflow,
    output logic             err_sticky
);

    // Pointers only need to address DEPTH entries
    localparam int              PW       = $clog2(DEPTH);
    localparam logic [PW-1:0]   LAST_PTR = PW'(DEPTH - 1);
    localparam logic [CW-1:0]   DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0]   AFULL_C  = CW'(AFULL_TH);
    localparam logic [CW-1:0]   AEMPTY_C = CW'(AEMPTY_TH);

    // Storage: deliberately not reset
    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [PW-1:0] rptr_q, rptr_d;
    logic [PW-1:0] wptr_q, wptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] free_q, free_d;
    logic [CW-1:0] hw_q, hw_d;
    logic          empty_q, empty_d;
    logic          full_q, full_d;
    logic          aempty_q, aempty_d;
    logic          afull_q, afull_d;
    logic          ovf_q, ovf_d;
    logic          unf_q, unf_d;
    logic          sticky_q, sticky_d;

    logic wr_acc;
    logic rd_acc;

    // Advance a pointer with an explicit wrap at the last entry
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    // Decide which requests are accepted; clear suppresses both
    always_comb begin
        wr_acc = wen & ~full_q  & ~clear;
        rd_acc = ren & ~empty_q & ~clear;
    end

    // Next-state for pointers, count, flags, high-water and error pulses
    always_comb begin
        rptr_d   = rptr_q;
        wptr_d   = wptr_q;
        count_d  = count_q;
        hw_d     = hw_q;
        ovf_d    = 1'b0;
        unf_d    = 1'b0;
        sticky_d = sticky_q;

        if (clear) begin
            rptr_d  = '0;
            wptr_d  = '0;
            count_d = '0;
            hw_d    = '0;
        end else begin
            if (wr_acc) begin
                wptr_d = ptr_inc(wptr_q);
            end
            if (rd_acc) begin
                rptr_d = ptr_inc(rptr_q);
            end
            count_d  = count_q + CW'(wr_acc) - CW'(rd_acc);
            ovf_d    = wen & full_q;
            unf_d    = ren & empty_q;
            sticky_d = sticky_q | ovf_d | unf_d;
            if (count_d > hw_q) begin
                hw_d = count_d;
            end
        end

        // All status is derived from the next count so nothing lags it
        free_d   = DEPTH_C - count_d;
        empty_d  = (count_d == '0);
        full_d   = (count_d == DEPTH_C);
        aempty_d = (count_d <= AEMPTY_C);
        afull_d  = (count_d >= AFULL_C);
    end

    // State register with synchronous reset taking priority over everything
    always_ff @(posedge clk) begin
        if (rst) begin
            rptr_q   <= '0;
            wptr_q   <= '0;
            count_q  <= '0;
            free_q   <= DEPTH_C;
            hw_q     <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
            aempty_q <= 1'b1;
            afull_q  <= 1'b0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            sticky_q <= 1'b0;
        end else begin
            rptr_q   <= rptr_d;
            wptr_q   <= wptr_d;
            count_q  <= count_d;
            free_q   <= free_d;
            hw_q     <= hw_d;
            empty_q  <= empty_d;
            full_q   <= full_d;
            aempty_q <= aempty_d;
            afull_q  <= afull_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
            sticky_q <= sticky_d;
        end
    end

    // Storage write; a write requested during reset is discarded
    always_ff @(posedge clk) begin
        if (wr_acc && !rst) begin
            mem_q[wptr_q] <= wdata;
        end
    end

    // Fall-through read of the head entry, optionally zeroed while empty
    always_comb begin
        rdata = mem_q[rptr_q];
        if (DATA_RESET && empty_q) begin
            rdata = '0;
        end
    end

    assign empty        = empty_q;
    assign full         = full_q;
    assign almost_empty = aempty_q;
    assign almost_full  = afull_q;
    assign used_slots   = count_q;
    assign free_slots   = free_q;
    assign high_water   = hw_q;
    assign underflow    = unf_q;
    assign overflow     = ovf_q;
    assign err_sticky   = sticky_q;

endmodule

// File: tb/tb_nx_fifo_wm.sv
// Self-checking bench for nx_fifo_wm (DEPTH=5, AFULL_TH=3, AEMPTY_TH=1).
module tb_nx_fifo_wm;

    localparam int DEPTH = 5;
    localparam int WIDTH = 16;
    localparam int CW    = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             clear = 1'b0;
    logic             wen = 1'b0;
    logic [WIDTH-1:0] wdata = '0;
    logic             ren = 1'b0;
    logic [WIDTH-1:0] rdata;
    logic             empty, full, almost_empty, almost_full;
    logic [CW-1:0]    used_slots, free_slots, high_water;
    logic             underflow, overflow, err_sticky;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [WIDTH-1:0] sb[$];
    int               mCount = 0;
    int               mHw = 0;
    logic             mOvf = 1'b0;
    logic             mUnf = 1'b0;
    logic             mSticky = 1'b0;
    logic [WIDTH-1:0] popExp;
    logic [WIDTH-1:0] popGot;
    logic             popValid = 1'b0;

    nx_fifo_wm #(
        .DEPTH(DEPTH), .WIDTH(WIDTH), .AFULL_TH(3), .AEMPTY_TH(1), .DATA_RESET(1'b1)
    ) dut (
        .clk(clk), .rst(rst), .clear(clear), .wen(wen), .wdata(wdata), .ren(ren),
        .rdata(rdata), .empty(empty), .full(full), .almost_empty(almost_empty),
        .almost_full(almost_full), .used_slots(used_slots), .free_slots(free_slots),
        .high_water(high_water), .underflow(underflow), .overflow(overflow),
        .err_sticky(err_sticky)
    );

    always #5 clk = ~clk;

    // One clock of stimulus; the model predicts acceptance, pushes written
    // data to the scoreboard and pops the expected head on an accepted read
    task automatic drive(input logic w, input logic [WIDTH-1:0] d, input logic r,
                         input logic clr, input logic rs);
        logic wacc, racc;
        wen = w; wdata = d; ren = r; clear = clr; rst = rs;
        popValid = 1'b0;
        if (rs) begin
            sb.delete(); mCount = 0; mHw = 0; mOvf = 0; mUnf = 0; mSticky = 0;
        end else if (clr) begin
            sb.delete(); mCount = 0; mHw = 0; mOvf = 0; mUnf = 0;
        end else begin
            wacc = w && (mCount < DEPTH);
            racc = r && (mCount > 0);
            mOvf = w && !wacc;
            mUnf = r && !racc;
            if (racc) begin
                popExp = sb.pop_front();
                popGot = rdata;
                popValid = 1'b1;
            end
            if (wacc) sb.push_back(d);
            mCount = mCount + int'(wacc) - int'(racc);
            if (mCount > mHw) mHw = mCount;
            mSticky = mSticky | mOvf | mUnf;
        end
        @(posedge clk);
        #1;
        wen = 0; ren = 0; clear = 0; rst = 0;
    endtask

    task automatic test_reset();
        drive(0, '0, 0, 0, 1);
        checks++; if (used_slots !== '0) begin errors++; $display("[TB] FAIL reset_used got %0d exp 0", used_slots); end
        checks++; if (free_slots !== CW'(DEPTH)) begin errors++; $display("[TB] FAIL reset_free got %0d exp %0d", free_slots, DEPTH); end
        checks++; if ({empty, full, almost_empty, almost_full} !== 4'b1010) begin errors++; $display("[TB] FAIL reset_flags got %b exp 1010", {empty, full, almost_empty, almost_full}); end
        checks++; if ({underflow, overflow, err_sticky} !== 3'b000) begin errors++; $display("[TB] FAIL reset_err got %b exp 000", {underflow, overflow, err_sticky}); end
        checks++; if (high_water !== '0) begin errors++; $display("[TB] FAIL reset_hw got %0d exp 0", high_water); end
        checks++; if (rdata !== '0) begin errors++; $display("[TB] FAIL reset_rdata got %h exp 0", rdata); end
    endtask

    task automatic test_overflow();
        drive(0, '0, 0, 0, 1);
        for (int i = 0; i < 7; i++) begin
            drive(1, WIDTH'(16'h0100 + i), 0, 0, 0);
            checks++; if (used_slots !== CW'(mCount)) begin errors++; $display("[TB] FAIL ovf_used[%0d] got %0d exp %0d", i, used_slots, mCount); end
            checks++; if (full !== (i >= 4)) begin errors++; $display("[TB] FAIL ovf_full[%0d] got %b exp %b", i, full, i >= 4); end
            checks++; if (overflow !== (i >= 5)) begin errors++; $display("[TB] FAIL ovf_pulse[%0d] got %b exp %b", i, overflow, i >= 5); end
        end
        checks++; if (err_sticky !== 1'b1) begin errors++; $display("[TB] FAIL ovf_sticky got %b exp 1", err_sticky); end
        drive(0, '0, 0, 0, 0);
        checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL ovf_pulse_end got %b exp 0", overflow); end
        for (int i = 0; i < 5; i++) begin
            drive(0, '0, 1, 0, 0);
            checks++; if (!popValid || popGot !== popExp) begin errors++; $display("[TB] FAIL ovf_drain[%0d] got %h exp %h", i, popGot, popExp); end
        end
        checks++; if (empty !== 1'b1 || rdata !== '0) begin errors++; $display("[TB] FAIL ovf_empty got empty=%b rdata=%h exp 1/0", empty, rdata); end
    endtask

    task automatic test_wrap();
        logic [WIDTH-1:0] v;
        drive(0, '0, 0, 0, 1);
        for (int i = 0; i < 12; i++) begin
            v = WIDTH'($urandom_range(0, 16'hFFFF));
            drive(1, v, (i >= 3), 0, 0);
            if (i >= 3) begin
                checks++; if (!popValid || popGot !== popExp) begin errors++; $display("[TB] FAIL wrap_data[%0d] got %h exp %h", i, popGot, popExp); end
            end
            checks++; if (dut.rptr_q >= DEPTH || dut.wptr_q >= DEPTH) begin errors++; $display("[TB] FAIL wrap_ptr[%0d] got r=%0d w=%0d exp <%0d", i, dut.rptr_q, dut.wptr_q, DEPTH); end
        end
        for (int i = 0; i < 3; i++) begin
            drive(0, '0, 1, 0, 0);
            checks++; if (!popValid || popGot !== popExp) begin errors++; $display("[TB] FAIL wrap_tail[%0d] got %h exp %h", i, popGot, popExp); end
        end
        checks++; if (empty !== 1'b1 || used_slots !== '0) begin errors++; $display("[TB] FAIL wrap_end got empty=%b used=%0d exp 1/0", empty, used_slots); end
    endtask

    task automatic test_back_to_back();
        drive(0, '0, 0, 0, 1);
        for (int i = 0; i < 5; i++) drive(1, WIDTH'(16'hA000 + i), 0, 0, 0);
        drive(1, 16'h5555, 1, 0, 0);
        checks++; if (overflow !== 1'b1 || used_slots !== CW'(4)) begin errors++; $display("[TB] FAIL full_rw got ovf=%b used=%0d exp 1/4", overflow, used_slots); end
        checks++; if (!popValid || popGot !== popExp) begin errors++; $display("[TB] FAIL full_rw_data got %h exp %h", popGot, popExp); end
        for (int i = 0; i < 4; i++) drive(0, '0, 1, 0, 0);
        drive(1, 16'hBEEF, 1, 0, 0);
        checks++; if (underflow !== 1'b1 || used_slots !== CW'(1)) begin errors++; $display("[TB] FAIL empty_rw got unf=%b used=%0d exp 1/1", underflow, used_slots); end
        checks++; if (rdata !== 16'hBEEF) begin errors++; $display("[TB] FAIL empty_rw_data got %h exp beef", rdata); end
        drive(0, '0, 0, 0, 0);
        checks++; if (underflow !== 1'b0) begin errors++; $display("[TB] FAIL unf_pulse_end got %b exp 0", underflow); end
    endtask

    task automatic test_watermarks();
        drive(0, '0, 0, 0, 1);
        for (int k = 0; k <= 4; k++) begin
            checks++; if (almost_empty !== (k <= 1) || almost_full !== (k >= 3)) begin errors++; $display("[TB] FAIL wm_fill[%0d] got ae=%b af=%b exp %b/%b", k, almost_empty, almost_full, k <= 1, k >= 3); end
            checks++; if (32'(used_slots) + 32'(free_slots) !== DEPTH) begin errors++; $display("[TB] FAIL wm_sum[%0d] got %0d exp %0d", k, used_slots + free_slots, DEPTH); end
            if (k < 4) drive(1, WIDTH'(k), 0, 0, 0);
        end
        for (int k = 4; k >= 0; k--) begin
            checks++; if (almost_empty !== (k <= 1) || almost_full !== (k >= 3)) begin errors++; $display("[TB] FAIL wm_drain[%0d] got ae=%b af=%b exp %b/%b", k, almost_empty, almost_full, k <= 1, k >= 3); end
            checks++; if (used_slots !== CW'(k)) begin errors++; $display("[TB] FAIL wm_used[%0d] got %0d exp %0d", k, used_slots, k); end
            if (k > 0) drive(0, '0, 1, 0, 0);
        end
        checks++; if (high_water !== CW'(mHw) || mHw != 4) begin errors++; $display("[TB] FAIL wm_hw got %0d exp 4", high_water); end
    endtask

    task automatic test_clear();
        drive(0, '0, 0, 0, 1);
        drive(0, '0, 1, 0, 0);
        checks++; if (underflow !== 1'b1) begin errors++; $display("[TB] FAIL clr_inject got %b exp 1", underflow); end
        for (int i = 0; i < 3; i++) drive(1, WIDTH'(16'hC000 + i), 0, 0, 0);
        drive(1, 16'hDEAD, 1, 1, 0);
        checks++; if (used_slots !== '0 || high_water !== '0 || empty !== 1'b1) begin errors++; $display("[TB] FAIL clr_state got used=%0d hw=%0d empty=%b exp 0/0/1", used_slots, high_water, empty); end
        checks++; if (underflow !== 1'b0 || overflow !== 1'b0) begin errors++; $display("[TB] FAIL clr_pulse got unf=%b ovf=%b exp 0/0", underflow, overflow); end
        checks++; if (err_sticky !== 1'b1) begin errors++; $display("[TB] FAIL clr_sticky got %b exp 1", err_sticky); end
        checks++; if (rdata !== '0) begin errors++; $display("[TB] FAIL clr_rdata got %h exp 0", rdata); end
        drive(1, 16'h1234, 0, 0, 1);
        checks++; if (err_sticky !== 1'b0 || used_slots !== '0) begin errors++; $display("[TB] FAIL rst_sticky got sticky=%b used=%0d exp 0/0", err_sticky, used_slots); end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_overflow();
        test_wrap();
        test_back_to_back();
        test_watermarks();
        test_clear();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
